pin_verifier: RTL and testbench

PIN_VERIFIER -- requirements
Module: pin_verifier

---
 rtl/pin_verifier.sv | 219 +++++++++++++++++++++
 tb/tb_pin_verifier.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_verifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pin_verifier                                                      |
// | Desc   : Single-digit PIN check FSM with per-card lockout and key timeout. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module pin_verifier #(
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       card_in,
  input  logic [7:0] cardno,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_enter,
  input  logic [3:0] correct_pin,
  input  logic       session_done,
  input  logic       admin_clear,
  output logic       pin_ok,
  output logic [3:0] pin_out,
  output logic [7:0] card_out,
  output logic       pin_bad,
  output logic       locked,
  output logic [1:0] tries_left,
  output logic       timeout_err
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [TRY_W-1:0] TRY_MAX    = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] TRY_ONE    = TRY_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [1:0]       TRIES_INIT = (MAX_TRIES > 3) ? 2'd3 : 2'(MAX_TRIES);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_KEY = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_GRANT    = 3'd3;
  localparam logic [2:0] S_FAIL     = 3'd4;
  localparam logic [2:0] S_LOCKED   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [7:0]       lock_q, lock_d;
  logic [7:0]       card_q, card_d;
  logic [3:0]       digit_q, digit_d;
  logic             digit_vld_q, digit_vld_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic             pin_ok_q, pin_ok_d;
  logic [3:0]       pin_out_q, pin_out_d;
  logic [7:0]       card_out_q, card_out_d;
  logic             pin_bad_q, pin_bad_d;
  logic             locked_q, locked_d;
  logic [1:0]       tries_left_q, tries_left_d;
  logic             timeout_err_q, timeout_err_d;

  logic             key_ok;
  logic             set_lock;
  logic             wrong_hit;
  logic             timeout_hit;

  function automatic logic [1:0] left_of(input logic [TRY_W-1:0] t);
    int rem;
    rem = MAX_TRIES - int'(t);
    if (rem <= 0)
      return 2'd0;
    else if (rem > 3)
      return 2'd3;
    else
      return 2'(rem);
  endfunction

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    card_d      = card_q;
    digit_d     = digit_q;
    digit_vld_d = digit_vld_q;
    tries_d     = tries_q;
    timer_d     = timer_q;
    set_lock    = 1'b0;
    wrong_hit   = 1'b0;
    timeout_hit = 1'b0;
    key_ok      = key_valid && (key_digit <= 4'd9);

    case (state_q)
      S_IDLE: begin
        if (card_in && (cardno != 8'd0)) begin
          card_d      = cardno;
          digit_d     = 4'd0;
          digit_vld_d = 1'b0;
          tries_d     = '0;
          timer_d     = '0;
          state_d     = lock_q[cardno[2:0]] ? S_LOCKED : S_WAIT_KEY;
        end
      end
      S_WAIT_KEY: begin
        if (key_ok) begin
          digit_d     = key_digit;
          digit_vld_d = 1'b1;
        end
        // Out-of-range digits are treated as idle cycles for the timer.
        if (key_enter) begin
          timer_d = '0;
          state_d = S_CHECK;
        end else if (key_ok) begin
          timer_d = '0;
        end else if (timer_q >= TMR_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      S_CHECK: begin
        if (digit_vld_q && (digit_q == correct_pin)) begin
          state_d = S_GRANT;
        end else begin
          wrong_hit = 1'b1;
          tries_d   = tries_q + TRY_ONE;
          if ((tries_q + TRY_ONE) == TRY_MAX) begin
            set_lock = 1'b1;
            state_d  = S_LOCKED;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_FAIL: begin
        digit_d     = 4'd0;
        digit_vld_d = 1'b0;
        timer_d     = '0;
        state_d     = S_WAIT_KEY;
      end
      S_GRANT: begin
        if (session_done)
          state_d = S_IDLE;
      end
      S_LOCKED: begin
        state_d = S_LOCKED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Card removal wins over every other transition out of a live session.
    if ((state_q != S_IDLE) && !card_in) begin
      state_d     = S_IDLE;
      tries_d     = tries_q;
      set_lock    = 1'b0;
      wrong_hit   = 1'b0;
      timeout_hit = 1'b0;
    end

    if (set_lock)
      lock_d[card_q[2:0]] = 1'b1;
    if (admin_clear)
      lock_d = '0;

    // Grant outputs need a full cycle in GRANT, so they rise one edge after the state.
    pin_ok_d      = (state_q == S_GRANT) && (state_d == S_GRANT);
    pin_out_d     = pin_ok_d ? digit_q : 4'd0;
    card_out_d    = pin_ok_d ? card_q : 8'd0;
    pin_bad_d     = wrong_hit;
    locked_d      = (state_d == S_LOCKED);
    timeout_err_d = timeout_hit;
    tries_left_d  = left_of(tries_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lock_q        <= '0;
      card_q        <= '0;
      digit_q       <= '0;
      digit_vld_q   <= 1'b0;
      tries_q       <= '0;
      timer_q       <= '0;
      pin_ok_q      <= 1'b0;
      pin_out_q     <= '0;
      card_out_q    <= '0;
      pin_bad_q     <= 1'b0;
      locked_q      <= 1'b0;
      tries_left_q  <= TRIES_INIT;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_q        <= lock_d;
      card_q        <= card_d;
      digit_q       <= digit_d;
      digit_vld_q   <= digit_vld_d;
      tries_q       <= tries_d;
      timer_q       <= timer_d;
      pin_ok_q      <= pin_ok_d;
      pin_out_q     <= pin_out_d;
      card_out_q    <= card_out_d;
      pin_bad_q     <= pin_bad_d;
      locked_q      <= locked_d;
      tries_left_q  <= tries_left_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign pin_ok      = pin_ok_q;
  assign pin_out     = pin_out_q;
  assign card_out    = card_out_q;
  assign pin_bad     = pin_bad_q;
  assign locked      = locked_q;
  assign tries_left  = tries_left_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pin_verifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_pin_verifier                                                   |
// | Desc   : Directed self-checking bench for pin_verifier.                    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_pin_verifier;

  logic       clk;
  logic       rst;
  logic       card_in;
  logic [7:0] cardno;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_enter;
  logic [3:0] correct_pin;
  logic       session_done;
  logic       admin_clear;
  logic       pin_ok;
  logic [3:0] pin_out;
  logic [7:0] card_out;
  logic       pin_bad;
  logic       locked;
  logic [1:0] tries_left;
  logic       timeout_err;

  int passed = 0;
  int total  = 0;

  pin_verifier #(
    .MAX_TRIES(3),
    .TIMEOUT  (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .card_in     (card_in),
    .cardno      (cardno),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .key_enter   (key_enter),
    .correct_pin (correct_pin),
    .session_done(session_done),
    .admin_clear (admin_clear),
    .pin_ok      (pin_ok),
    .pin_out     (pin_out),
    .card_out    (card_out),
    .pin_bad     (pin_bad),
    .locked      (locked),
    .tries_left  (tries_left),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic insert(input logic [7:0] c, input logic [3:0] p);
    cardno      = c;
    correct_pin = p;
    card_in     = 1'b1;
    step(1);
  endtask

  task automatic remove_card();
    card_in = 1'b0;
    cardno  = 8'd0;
    step(1);
  endtask

  // Digit and enter in the same cycle, then let CHECK resolve.
  task automatic enter_key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    key_enter = 1'b1;
    step(1);
    key_valid = 1'b0;
    key_enter = 1'b0;
    step(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pin_ok"},      32'(pin_ok),      0);
    chk({tag, "_pin_bad"},     32'(pin_bad),     0);
    chk({tag, "_locked"},      32'(locked),      0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    chk({tag, "_pin_out"},     32'(pin_out),     0);
    chk({tag, "_card_out"},    32'(card_out),    0);
    chk({tag, "_tries_left"},  32'(tries_left),  3);
  endtask

  initial begin
    rst          = 1'b1;
    card_in      = 1'b0;
    cardno       = 8'd0;
    key_valid    = 1'b0;
    key_digit    = 4'd0;
    key_enter    = 1'b0;
    correct_pin  = 4'd0;
    session_done = 1'b0;
    admin_clear  = 1'b0;
    step(2);
    chk_reset_outputs("reset");
    rst = 1'b0;
    step(1);

    // Grant on 0x15 / PIN 7; an earlier digit 3 is overwritten by 7.
    insert(8'h15, 4'd7);
    key_valid = 1'b1;
    key_digit = 4'd3;
    step(1);
    key_digit = 4'd7;
    step(1);
    key_valid = 1'b0;
    key_enter = 1'b1;
    step(1);
    key_enter = 1'b0;
    chk("grant_e0_pin_ok", 32'(pin_ok), 0);
    step(1);
    chk("grant_e1_pin_ok", 32'(pin_ok), 0);
    step(1);
    chk("grant_e2_pin_ok",   32'(pin_ok),     1);
    chk("grant_pin_out",     32'(pin_out),    7);
    chk("grant_card_out",    32'(card_out),   'h15);
    chk("grant_tries_left",  32'(tries_left), 3);
    step(2);
    chk("grant_held",        32'(pin_ok),     1);
    session_done = 1'b1;
    cardno       = 8'd0;
    step(1);
    session_done = 1'b0;
    chk("done_pin_ok",   32'(pin_ok),   0);
    chk("done_pin_out",  32'(pin_out),  0);
    chk("done_card_out", 32'(card_out), 0);
    step(1);
    chk("idle_card0_pin_ok", 32'(pin_ok), 0);
    remove_card();

    // Lockout of 0x0B with wrong digits 1, 2, 3.
    insert(8'h0B, 4'd4);
    enter_key(4'd1);
    chk("wrong1_pin_bad",    32'(pin_bad),    1);
    chk("wrong1_tries_left", 32'(tries_left), 2);
    step(1);
    chk("wrong1_pulse_end",  32'(pin_bad),    0);
    enter_key(4'd2);
    chk("wrong2_pin_bad",    32'(pin_bad),    1);
    chk("wrong2_tries_left", 32'(tries_left), 1);
    step(1);
    enter_key(4'd3);
    chk("wrong3_pin_bad",    32'(pin_bad),    1);
    chk("wrong3_tries_left", 32'(tries_left), 0);
    chk("wrong3_locked",     32'(locked),     1);
    step(1);
    chk("locked_pin_bad_end", 32'(pin_bad), 0);
    chk("locked_level",       32'(locked),  1);
    enter_key(4'd4);
    step(1);
    chk("locked_keys_ignored", 32'(pin_ok), 0);
    chk("locked_still",        32'(locked), 1);
    remove_card();
    chk("unlock_on_removal", 32'(locked), 0);
    insert(8'h03, 4'd4);
    chk("reinsert_locked",     32'(locked),     1);
    chk("reinsert_no_pin_bad", 32'(pin_bad),    0);
    chk("reinsert_tries_left", 32'(tries_left), 3);
    remove_card();

    // Out-of-range digit followed by enter counts as a wrong entry.
    insert(8'h21, 4'd0);
    key_valid = 1'b1;
    key_digit = 4'hC;
    step(1);
    key_valid = 1'b0;
    key_enter = 1'b1;
    step(1);
    key_enter = 1'b0;
    step(1);
    chk("invalid_pin_bad",    32'(pin_bad),    1);
    chk("invalid_tries_left", 32'(tries_left), 2);
    step(1);
    remove_card();
    insert(8'h21, 4'd0);
    chk("removal_restart_tries", 32'(tries_left), 3);
    enter_key(4'd0);
    step(1);
    chk("pin0_grant_ok",       32'(pin_ok),   1);
    chk("pin0_grant_pin_out",  32'(pin_out),  0);
    chk("pin0_grant_card_out", 32'(card_out), 'h21);
    remove_card();
    chk("removal_grant_pin_ok", 32'(pin_ok), 0);

    // Timeout: an out-of-range digit does not restart the timer.
    insert(8'h22, 4'd0);
    key_valid = 1'b1;
    key_digit = 4'hF;
    step(1);
    key_valid = 1'b0;
    step(3);
    chk("timeout_early", 32'(timeout_err), 0);
    step(1);
    chk("timeout_pulse",  32'(timeout_err), 1);
    chk("timeout_pin_ok", 32'(pin_ok),      0);
    step(1);
    chk("timeout_pulse_end", 32'(timeout_err), 0);
    chk("timeout_no_charge", 32'(tries_left),  3);
    remove_card();

    // Admin clear releases the lock on 0x0B.
    admin_clear = 1'b1;
    step(1);
    admin_clear = 1'b0;
    insert(8'h0B, 4'd4);
    chk("admin_unlocked", 32'(locked), 0);
    enter_key(4'd4);
    step(1);
    chk("admin_grant_ok",   32'(pin_ok),   1);
    chk("admin_grant_card", 32'(card_out), 'h0B);
    remove_card();

    // Lock 0x05, then reset in the middle of a grant on 0x0B.
    insert(8'h05, 4'd9);
    enter_key(4'd1);
    step(1);
    enter_key(4'd1);
    step(1);
    enter_key(4'd1);
    chk("lock5_locked", 32'(locked), 1);
    remove_card();
    insert(8'h0B, 4'd4);
    enter_key(4'd4);
    step(1);
    chk("pre_reset_grant", 32'(pin_ok), 1);
    rst = 1'b1;
    step(1);
    chk_reset_outputs("midgrant_reset");
    card_in = 1'b0;
    cardno  = 8'd0;
    step(1);
    rst = 1'b0;
    step(1);
    insert(8'h05, 4'd9);
    chk("reset_cleared_locks", 32'(locked), 0);
    remove_card();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
